anomaly_detector: RTL and testbench
===================================

ANOMALY_DETECTOR -- requirements
Module: anomaly_detector

Interface
REQ-001 Parameter WIN_LOG2, default 6: observation window is 2^WIN_LOG2 cycles (64).
REQ-002 Parameter CRASH_DROP, default 16: minimum price drop in ticks that flags FLASH_CRASH.
REQ-003 Parameter STUFF_THRESH, default 48: minimum orders per window that flags QUOTE_STUFFING.
REQ-004 Parameter IMB_THRESH, default 24: minimum |buys-sells| per window that flags ORDER_IMBALANCE.
REQ-005 Parameter HOLDOFF_WIN, default 2: window closes skipped after a cb_load is issued.
REQ-006 clk  input  1  clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 input_type  input  2  order stream; 2'b10 = buy, 2'b11 = sell, other values = no order.
REQ-009 match_valid  input  1  one-cycle trade strobe from the order book.
REQ-010 match_price  input  8  trade price, qualified by match_valid.
REQ-011 cb_mode  output  2  circuit-breaker mode; 00 normal, 01 throttle, 10 widen, 11 pause.
REQ-012 cb_param  output  8  confidence parameter for cb_mode.
REQ-013 cb_load  output  1  one-cycle pulse; cb_mode/cb_param are valid in that cycle.

Function
REQ-014 Free-running WIN_LOG2-bit window counter increments every cycle from 0 after reset; window closes in the cycle it equals all-ones (cycle T).
REQ-015 Live counters: orders (buy or sell), buys, sells, each WIN_LOG2+1 bits, never overflow; min_price tracks lowest match_price in window; last_price tracks most recent match_price; match_seen flag.
REQ-016 Events in cycle T count in the closing window; at T all live values snapshot into eval registers; live counters clear to 0, min_price to 8'hFF, match_seen to 0, effective at T+1.
REQ-017 At T, if match_seen, ref_price <= last_price and ref_valid <= 1; otherwise ref_price/ref_valid hold; the update occurs during HOLDOFF too.
REQ-018 Evaluation uses ref_price as it was before the T update (previous window's last trade).
REQ-019 FSM states MONITOR, EVAL, HOLDOFF; MONITOR -> EVAL at T; EVAL -> HOLDOFF if an anomaly is flagged, else MONITOR.
REQ-020 Anomaly priority in EVAL (first match wins): FLASH_CRASH if snapshot match_seen, ref_valid, ref_price > min_price and drop = ref_price - min_price >= CRASH_DROP; then QUOTE_STUFFING if orders >= STUFF_THRESH; then ORDER_IMBALANCE if |buys-sells| >= IMB_THRESH.
REQ-021 cb_param: FLASH_CRASH = drop*8, QUOTE_STUFFING = orders*4, ORDER_IMBALANCE = diff*8; each saturates at 255.
REQ-022 cb_mode: FLASH_CRASH 2'b11, QUOTE_STUFFING 2'b01, ORDER_IMBALANCE 2'b10.
REQ-023 cb_load asserts at T+2 for exactly one cycle; cb_mode/cb_param update in that same cycle and hold until the next load.
REQ-024 HOLDOFF counts window closes; after HOLDOFF_WIN closes it returns to MONITOR; no evaluation and no cb_load occur at closes counted in HOLDOFF. The close that ends HOLDOFF is not evaluated.
REQ-025 No anomaly -> no cb_load, and outputs hold.
REQ-026 A match_valid with price above ref_price never flags a crash, because drop is unsigned and guarded.

Reset
REQ-027 rst_n low asynchronously clears window counter, all live and eval counters, ref_valid, ref_price, last_price and match_seen to 0, and sets min_price to 8'hFF.
REQ-028 During reset cb_mode = 2'b00, cb_param = 8'h00, cb_load = 0, and FSM = MONITOR; reset mid-EVAL or mid-HOLDOFF suppresses any pending cb_load.

Configuration
REQ-029 Macro ANOMALY_OVERRIDE_EN defined: adds inputs ovr_valid (1), ovr_mode (2) and ovr_param (8).
REQ-030 ovr_valid high at cycle C produces cb_load at C+1 with ovr_mode/ovr_param. This takes precedence over a simultaneous detector load, which is discarded, and it enters HOLDOFF with the close count restarted.
REQ-031 Macro not defined: override ports and logic are absent, and behaviour is REQ-001 to REQ-028 only.

Verification
REQ-032 Window 0: one match at price 100. Window 1: matches at 90 and then 80 -> cb_load at T+2 of window 1 with cb_mode 11 and cb_param 160.
REQ-033 50 buy orders in one window with no matches -> cb_mode 01, cb_param 200. With 64 orders -> cb_param 255, saturated.
REQ-034 30 buys and 4 sells in one window -> cb_mode 10, cb_param 208. With 20 buys and 4 sells -> no cb_load.
REQ-035 Anomaly repeated in 4 consecutive windows -> cb_load after windows 0 and 3 only, because of HOLDOFF_WIN = 2.
REQ-036 Order and match in cycle T (counter 63) -> both counted in the closing window. Reset asserted at T+1 -> no cb_load, and all outputs are 0.
REQ-037 With ANOMALY_OVERRIDE_EN: ovr_valid at the T+1 of a stuffing window with ovr_mode 00 -> single cb_load at T+2 with cb_mode 00 and cb_param = ovr_param.

Source files
------------

// File: rtl/anomaly_detector.sv
// Market anomaly detector: windowed order/trade statistics driving circuit-breaker loads.
// Optional external override path is compiled in with `define ANOMALY_OVERRIDE_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// MONITOR   | accumulating the current window, waiting for its close
// EVAL      | one cycle after a close: classify the snapshot, maybe load
// HOLDOFF   | after a load: skip HOLDOFF_WIN window closes unevaluated
module anomaly_detector #(
    parameter int unsigned WIN_LOG2     = 6,
    parameter int unsigned CRASH_DROP   = 16,
    parameter int unsigned STUFF_THRESH = 48,
    parameter int unsigned IMB_THRESH   = 24,
    parameter int unsigned HOLDOFF_WIN  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] input_type,
    input  logic       match_valid,
    input  logic [7:0] match_price,
`ifdef ANOMALY_OVERRIDE_EN
    input  logic       ovr_valid,
    input  logic [1:0] ovr_mode,
    input  logic [7:0] ovr_param,
`endif
    output logic [1:0] cb_mode,
    output logic [7:0] cb_param,
    output logic       cb_load
);

    localparam int unsigned CW = WIN_LOG2 + 1;

    typedef enum logic [1:0] {S_MONITOR, S_EVAL, S_HOLDOFF} state_t;

    state_t state_q, state_d;

    logic [WIN_LOG2-1:0] win_q;
    logic [CW-1:0]       orders_q, buys_q, sells_q;
    logic [CW-1:0]       orders_d, buys_d, sells_d;
    logic [7:0]          min_q, last_q, min_d, last_d;
    logic                seen_q, seen_d;
    logic [7:0]          ref_q;
    logic                ref_valid_q;

    logic [CW-1:0]       ev_orders_q, ev_buys_q, ev_sells_q;
    logic [7:0]          ev_min_q, ev_ref_q;
    logic                ev_seen_q, ev_ref_valid_q;

    logic [7:0]          hcnt_q, hcnt_d, hcnt_inc;
    logic [1:0]          cb_mode_q, cb_mode_d;
    logic [7:0]          cb_param_q, cb_param_d;
    logic                cb_load_q, cb_load_d;

    logic                close, is_buy, is_sell, is_order;
    logic [CW-1:0]       diff;
    logic [7:0]          drop;
    logic                crash_hit, stuff_hit, imb_hit, anomaly;
    logic [7:0]          crash_param, stuff_param, imb_param;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    assign close    = &win_q;
    assign is_buy   = (input_type == 2'b10);
    assign is_sell  = (input_type == 2'b11);
    assign is_order = is_buy | is_sell;

    // Next live values include this cycle's events, so cycle T counts in the closing window.
    assign orders_d = orders_q + {{(CW-1){1'b0}}, is_order};
    assign buys_d   = buys_q + {{(CW-1){1'b0}}, is_buy};
    assign sells_d  = sells_q + {{(CW-1){1'b0}}, is_sell};
    assign min_d    = (match_valid && (match_price < min_q)) ? match_price : min_q;
    assign last_d   = match_valid ? match_price : last_q;
    assign seen_d   = seen_q | match_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q          <= '0;
            orders_q       <= '0;
            buys_q         <= '0;
            sells_q        <= '0;
            min_q          <= 8'hFF;
            last_q         <= 8'h00;
            seen_q         <= 1'b0;
            ref_q          <= 8'h00;
            ref_valid_q    <= 1'b0;
            ev_orders_q    <= '0;
            ev_buys_q      <= '0;
            ev_sells_q     <= '0;
            ev_min_q       <= 8'hFF;
            ev_ref_q       <= 8'h00;
            ev_seen_q      <= 1'b0;
            ev_ref_valid_q <= 1'b0;
        end else begin
            win_q <= win_q + 1'b1;
            if (close) begin
                ev_orders_q    <= orders_d;
                ev_buys_q      <= buys_d;
                ev_sells_q     <= sells_d;
                ev_min_q       <= min_d;
                ev_seen_q      <= seen_d;
                ev_ref_q       <= ref_q;
                ev_ref_valid_q <= ref_valid_q;
                if (seen_d) begin
                    ref_q       <= last_d;
                    ref_valid_q <= 1'b1;
                end
                orders_q <= '0;
                buys_q   <= '0;
                sells_q  <= '0;
                min_q    <= 8'hFF;
                last_q   <= last_d;
                seen_q   <= 1'b0;
            end else begin
                orders_q <= orders_d;
                buys_q   <= buys_d;
                sells_q  <= sells_d;
                min_q    <= min_d;
                last_q   <= last_d;
                seen_q   <= seen_d;
            end
        end
    end

    assign diff = (ev_buys_q >= ev_sells_q) ? (ev_buys_q - ev_sells_q)
                                            : (ev_sells_q - ev_buys_q);
    assign drop = ev_ref_q - ev_min_q;

    // The ref > min guard keeps a price rise from wrapping into a large unsigned drop.
    assign crash_hit = ev_seen_q && ev_ref_valid_q && (ev_ref_q > ev_min_q)
                       && (32'(drop) >= CRASH_DROP);
    assign stuff_hit = (32'(ev_orders_q) >= STUFF_THRESH);
    assign imb_hit   = (32'(diff) >= IMB_THRESH);
    assign anomaly   = crash_hit | stuff_hit | imb_hit;

    assign crash_param = sat8(32'(drop) << 3);
    assign stuff_param = sat8(32'(ev_orders_q) << 2);
    assign imb_param   = sat8(32'(diff) << 3);

    assign hcnt_inc = hcnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_MONITOR;
            hcnt_q     <= 8'd0;
            cb_mode_q  <= 2'b00;
            cb_param_q <= 8'h00;
            cb_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            cb_mode_q  <= cb_mode_d;
            cb_param_q <= cb_param_d;
            cb_load_q  <= cb_load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            S_MONITOR: if (close) state_d = S_EVAL;
            S_EVAL:    state_d = anomaly ? S_HOLDOFF : S_MONITOR;
            S_HOLDOFF: begin
                if (close) begin
                    hcnt_d = hcnt_inc;
                    if (32'(hcnt_inc) >= HOLDOFF_WIN) state_d = S_MONITOR;
                end
            end
            default:   state_d = S_MONITOR;
        endcase
`ifdef ANOMALY_OVERRIDE_EN
        if (ovr_valid) state_d = S_HOLDOFF;
        if (ovr_valid) hcnt_d = 8'd0;
`endif
        if (state_d != S_HOLDOFF) hcnt_d = 8'd0;
    end

    always_comb begin
        cb_mode_d  = cb_mode_q;
        cb_param_d = cb_param_q;
        cb_load_d  = 1'b0;
        if (state_q == S_EVAL) begin
            if (crash_hit) begin
                cb_mode_d  = 2'b11;
                cb_param_d = crash_param;
                cb_load_d  = 1'b1;
            end else if (stuff_hit) begin
                cb_mode_d  = 2'b01;
                cb_param_d = stuff_param;
                cb_load_d  = 1'b1;
            end else if (imb_hit) begin
                cb_mode_d  = 2'b10;
                cb_param_d = imb_param;
                cb_load_d  = 1'b1;
            end
        end
`ifdef ANOMALY_OVERRIDE_EN
        if (ovr_valid) begin
            cb_mode_d  = ovr_mode;
            cb_param_d = ovr_param;
            cb_load_d  = 1'b1;
        end
`endif
    end

    assign cb_mode  = cb_mode_q;
    assign cb_param = cb_param_q;
    assign cb_load  = cb_load_q;

endmodule

// File: tb/tb_anomaly_detector.sv
// Bench for anomaly_detector: table of two-window scenarios plus hand-written corner sequences.
// Expected loads are queued when stimulus is driven and matched when cb_load pulses.
module tb_anomaly_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] input_type;
    logic       match_valid;
    logic [7:0] match_price;
    logic [1:0] cb_mode;
    logic [7:0] cb_param;
    logic       cb_load;
`ifdef ANOMALY_OVERRIDE_EN
    logic       ovr_valid;
    logic [1:0] ovr_mode;
    logic [7:0] ovr_param;
`endif

    anomaly_detector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_type  (input_type),
        .match_valid (match_valid),
        .match_price (match_price),
`ifdef ANOMALY_OVERRIDE_EN
        .ovr_valid   (ovr_valid),
        .ovr_mode    (ovr_mode),
        .ovr_param   (ovr_param),
`endif
        .cb_mode     (cb_mode),
        .cb_param    (cb_param),
        .cb_load     (cb_load)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] param;
        int         cyc;
    } exp_t;

    typedef struct {
        int         ref_p;
        int         p1;
        int         p2;
        int         nb;
        int         ns;
        bit         exp_load;
        logic [1:0] mode;
        logic [7:0] param;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    // cyc equals the DUT window-counter position during each cycle after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1 && cb_load === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_load", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("load_cycle", cyc, e.cyc);
                check("load_mode", int'(cb_mode), int'(e.mode));
                check("load_param", int'(cb_param), int'(e.param));
            end
        end
    end

    task automatic clear_inputs();
        input_type  = 2'b00;
        match_valid = 1'b0;
        match_price = 8'h00;
`ifdef ANOMALY_OVERRIDE_EN
        ovr_valid = 1'b0;
        ovr_mode  = 2'b00;
        ovr_param = 8'h00;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("rst_mode", int'(cb_mode), 0);
        check("rst_param", int'(cb_param), 0);
        check("rst_load", int'(cb_load), 0);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) @(negedge clk);
    endtask

    // One 64-cycle window: nb buys then ns sells from cycle ostart; matches at cycles ca/cb.
    task automatic drive_window(input int nb, input int ns, input int ostart,
                                input int pa, input int ca, input int pb, input int cb);
        for (int c = 0; c < 64; c++) begin
            if (c >= ostart && c < ostart + nb)           input_type = 2'b10;
            else if (c >= ostart + nb && c < ostart + nb + ns) input_type = 2'b11;
            else input_type = 2'($urandom_range(0, 1));
            if (c == ca) begin
                match_valid = 1'b1;
                match_price = 8'(pa);
            end else if (c == cb) begin
                match_valid = 1'b1;
                match_price = 8'(pb);
            end else begin
                match_valid = 1'b0;
                match_price = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        //          ref  p1   p2  nb  ns  load mode   param
        vecs[0]  = '{100, 90,  80,  0,  0, 1'b1, 2'b11, 8'd160};
        vecs[1]  = '{  0,  0,   0, 50,  0, 1'b1, 2'b01, 8'd200};
        vecs[2]  = '{  0,  0,   0, 64,  0, 1'b1, 2'b01, 8'd255};
        vecs[3]  = '{  0,  0,   0, 30,  4, 1'b1, 2'b10, 8'd208};
        vecs[4]  = '{  0,  0,   0, 20,  4, 1'b0, 2'b00, 8'd0};
        vecs[5]  = '{100, 120,  0,  0,  0, 1'b0, 2'b00, 8'd0};
        vecs[6]  = '{100, 84,   0,  0,  0, 1'b1, 2'b11, 8'd128};
        vecs[7]  = '{100, 85,   0,  0,  0, 1'b0, 2'b00, 8'd0};
        vecs[8]  = '{  0,  0,   0, 24, 24, 1'b1, 2'b01, 8'd192};
        vecs[9]  = '{  0,  0,   0, 47,  0, 1'b1, 2'b10, 8'd255};
        vecs[10] = '{200, 100,  0, 50,  0, 1'b1, 2'b11, 8'd255};
        vecs[11] = '{  0, 10,   0,  0,  0, 1'b0, 2'b00, 8'd0};
        vecs[12] = '{  0,  0,   0,  0, 24, 1'b1, 2'b10, 8'd192};
        vecs[13] = '{  0,  0,   0,  0, 23, 1'b0, 2'b00, 8'd0};

        for (int i = 0; i < 14; i++) begin
            do_reset();
            if (vecs[i].exp_load)
                sbq.push_back('{vecs[i].mode, vecs[i].param, 129});
            drive_window(0, 0, 0, vecs[i].ref_p, (vecs[i].ref_p != 0) ? 10 : -1, 0, -1);
            drive_window(vecs[i].nb, vecs[i].ns, 0,
                         vecs[i].p1, (vecs[i].p1 != 0) ? 20 : -1,
                         vecs[i].p2, (vecs[i].p2 != 0) ? 40 : -1);
            idle(8);
            check($sformatf("vec%0d_missing_load", i), sbq.size(), 0);
            sbq.delete();
            check($sformatf("vec%0d_hold_mode", i), int'(cb_mode), int'(vecs[i].mode));
            check($sformatf("vec%0d_hold_param", i), int'(cb_param), int'(vecs[i].param));
        end

        // Stuffing in four consecutive windows: loads after windows 0 and 3 only.
        do_reset();
        sbq.push_back('{2'b01, 8'd200, 65});
        sbq.push_back('{2'b01, 8'd200, 257});
        repeat (4) drive_window(50, 0, 0, 0, -1, 0, -1);
        idle(10);
        check("holdoff_missing_load", sbq.size(), 0);
        sbq.delete();

        // Order in the closing cycle counts: 48 buys ending at cycle 63.
        do_reset();
        sbq.push_back('{2'b01, 8'd192, 65});
        drive_window(48, 0, 16, 0, -1, 0, -1);
        idle(8);
        check("close_order_missing_load", sbq.size(), 0);
        sbq.delete();

        // Trade in the closing cycle becomes the reference price.
        do_reset();
        sbq.push_back('{2'b11, 8'd160, 129});
        drive_window(0, 0, 0, 100, 63, 0, -1);
        drive_window(0, 0, 0, 80, 5, 0, -1);
        idle(8);
        check("close_match_missing_load", sbq.size(), 0);
        sbq.delete();

        // Reset at T+1 of a stuffing window suppresses the pending load and clears held outputs.
        do_reset();
        sbq.push_back('{2'b01, 8'd200, 65});
        drive_window(50, 0, 0, 0, -1, 0, -1);
        drive_window(0, 0, 0, 0, -1, 0, -1);
        drive_window(0, 0, 0, 0, -1, 0, -1);
        drive_window(48, 0, 16, 0, -1, 0, -1);
        check("pre_rst_mode", int'(cb_mode), 1);
        check("pre_rst_param", int'(cb_param), 200);
        rst_n = 1'b0;
        #1;
        check("midrst_mode", int'(cb_mode), 0);
        check("midrst_param", int'(cb_param), 0);
        check("midrst_load", int'(cb_load), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check("midrst_missing_load", sbq.size(), 0);
        sbq.delete();
        check("post_rst_mode", int'(cb_mode), 0);
        check("post_rst_param", int'(cb_param), 0);

`ifdef ANOMALY_OVERRIDE_EN
        // Override in the evaluation cycle replaces the detector's stuffing load.
        do_reset();
        sbq.push_back('{2'b00, 8'h5A, 65});
        drive_window(50, 0, 0, 0, -1, 0, -1);
        ovr_valid = 1'b1;
        ovr_mode  = 2'b00;
        ovr_param = 8'h5A;
        @(negedge clk);
        idle(10);
        check("ovr_missing_load", sbq.size(), 0);
        sbq.delete();
        check("ovr_hold_mode", int'(cb_mode), 0);
        check("ovr_hold_param", int'(cb_param), 8'h5A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
